// File: rtl/apb_otp_multikey_if.sv
// APB slave bus bundle for the multi-slot one-time-pad engine.
// The master modport drives the request side, the slave modport returns
// read data and the completion/error handshake.
interface apb_otp_multikey_if #(
  parameter int WIDTH = 128
);
  logic [31:0]      paddr;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [2:0]       pprot;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pprot, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pprot, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_otp_multikey.sv
// Multi-slot one-time-pad engine on an APB slave port.
// A DATA write is XORed with the selected privileged key after LATENCY
// cycles; the result can be read exactly once and that read zeroizes the
// key slot that produced it.
// Optional feature: define APB_OTP_KEY_LOCK_EN to make every key slot
// write-once per reset (locked bits are cleared only by preset_n).
module apb_otp_multikey #(
  parameter int WIDTH   = 128,
  parameter int NKEYS   = 4,
  parameter int LATENCY = 2
) (
  input  logic               pclk,
  input  logic               preset_n,
  apb_otp_multikey_if.slave  bus
);

  localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] key [NKEYS];
  logic [NKEYS-1:0] valid;
  logic [NKEYS-1:0] locked;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] result;
  logic [2:0]       sel;
  logic [IW-1:0]    act;
  logic [CW-1:0]    cnt;

  logic             access;
  logic             is_ctrl, is_data, is_result, is_status, is_key;
  logic [IW-1:0]    kidx;
  logic             sel_ok;

  logic             do_ctrl, do_data, do_key, do_consume;
  logic             rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] status;

  assign access    = bus.psel & bus.penable;
  assign is_ctrl   = (bus.paddr == 32'h0000_0000);
  assign is_data   = (bus.paddr == 32'h0000_0001);
  assign is_result = (bus.paddr == 32'h0000_0002);
  assign is_status = (bus.paddr == 32'h0000_0003);
  assign is_key    = (bus.paddr >= 32'h0000_0010) && (bus.paddr < 32'(16 + NKEYS));
  assign kidx      = bus.paddr[IW-1:0];
  assign sel_ok    = ({29'b0, bus.pwdata[2:0]} < 32'(NKEYS));

`ifndef APB_OTP_KEY_LOCK_EN
  assign locked = '0;
`endif

  // Build the STATUS word from the live slot and FSM state.
  always_comb begin
    status            = '0;
    status[NKEYS-1:0] = valid;
    status[8 +: NKEYS] = locked;
    status[16]        = (state == BUSY);
    status[17]        = (state == DONE);
    status[26:24]     = sel;
  end

  // Decode the access phase into a combinational APB response and the
  // set of state updates that happen at the closing pclk edge.
  always_comb begin
    rsp_ready  = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    do_ctrl    = 1'b0;
    do_data    = 1'b0;
    do_key     = 1'b0;
    do_consume = 1'b0;
    if (access) begin
      rsp_ready = 1'b1;
      if (is_ctrl) begin
        if (bus.pwrite && bus.pprot[0] && sel_ok) do_ctrl = 1'b1;
        else                                      rsp_err = 1'b1;
      end else if (is_data) begin
        if (bus.pwrite && (state != BUSY) && valid[sel[IW-1:0]]) do_data = 1'b1;
        else                                                     rsp_err = 1'b1;
      end else if (is_key) begin
        if (bus.pwrite && bus.pprot[0] && !locked[kidx] &&
            !((state != IDLE) && (act == kidx)))
          do_key = 1'b1;
        else
          rsp_err = 1'b1;
      end else if (is_result) begin
        if (bus.pwrite || (bus.pprot[2:1] != 2'b00) || (state == IDLE)) begin
          rsp_err = 1'b1;
        end else if (state == BUSY) begin
          rsp_ready = 1'b0;
        end else begin
          rsp_data   = result;
          do_consume = 1'b1;
        end
      end else if (is_status) begin
        if (bus.pwrite) rsp_err  = 1'b1;
        else            rsp_data = status;
      end else begin
        rsp_err = 1'b1;
      end
    end
  end

  assign bus.prdata  = rsp_data;
  assign bus.pready  = rsp_ready;
  assign bus.pslverr = rsp_err;

  // FSM, key storage and datapath; later assignments take priority so a
  // clear-all overrides any in-flight operation.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state  <= IDLE;
      for (int i = 0; i < NKEYS; i++) key[i] <= '0;
      valid  <= '0;
      data   <= '0;
      result <= '0;
      sel    <= '0;
      act    <= '0;
      cnt    <= '0;
`ifdef APB_OTP_KEY_LOCK_EN
      locked <= '0;
`endif
    end else begin
      if (state == BUSY) begin
        if (cnt == '0) begin
          result <= data ^ key[act];
          state  <= DONE;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (do_consume) begin
        result     <= '0;
        data       <= '0;
        key[act]   <= '0;
        valid[act] <= 1'b0;
        state      <= IDLE;
      end
      if (do_data) begin
        data   <= bus.pwdata;
        act    <= sel[IW-1:0];
        cnt    <= CW'(LATENCY - 1);
        result <= '0;
        state  <= BUSY;
      end
      if (do_key) begin
        key[kidx]   <= bus.pwdata;
        valid[kidx] <= 1'b1;
`ifdef APB_OTP_KEY_LOCK_EN
        locked[kidx] <= 1'b1;
`endif
      end
      if (do_ctrl) begin
        sel <= bus.pwdata[2:0];
        if (bus.pwdata[8]) begin
          for (int i = 0; i < NKEYS; i++) key[i] <= '0;
          valid  <= '0;
          data   <= '0;
          result <= '0;
          state  <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_otp_multikey.sv
// Scoreboard bench for apb_otp_multikey (WIDTH=128, NKEYS=4, LATENCY=4).
// The driver pushes each transfer's expected response; an independent
// monitor pops and compares whenever a transfer completes.
module tb_apb_otp_multikey;

  localparam int WIDTH   = 128;
  localparam int NKEYS   = 4;
  localparam int LATENCY = 4;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_DATA   = 32'h01;
  localparam logic [31:0] A_RESULT = 32'h02;
  localparam logic [31:0] A_STATUS = 32'h03;
  localparam logic [31:0] A_KEY0   = 32'h10;

  logic pclk;
  logic preset_n;

  apb_otp_multikey_if #(.WIDTH(WIDTH)) bus ();

  apb_otp_multikey #(.WIDTH(WIDTH), .NKEYS(NKEYS), .LATENCY(LATENCY)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  int assert_count = 0;
  int fail_count   = 0;
  int last_waits   = 0;

  logic [WIDTH-1:0] exp_data_q [$];
  logic             exp_err_q  [$];
  string            exp_name_q [$];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every completed transfer is checked against the scoreboard.
  always @(negedge pclk) begin
    if (preset_n && bus.psel && bus.penable && bus.pready) begin
      if (exp_data_q.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected_completion: got response with empty scoreboard, expected none");
      end else begin
        string            nm;
        logic [WIDTH-1:0] ed;
        logic             ee;
        nm = exp_name_q.pop_front();
        ed = exp_data_q.pop_front();
        ee = exp_err_q.pop_front();
        checkOutput({nm, ".prdata"}, bus.prdata, ed);
        checkOutput({nm, ".pslverr"}, {{(WIDTH-1){1'b0}}, bus.pslverr}, {{(WIDTH-1){1'b0}}, ee});
      end
    end
  end

  // One APB transfer; called at posedge+1 and returns at posedge+1.
  task automatic applyStimulus(input string name, input logic [31:0] addr,
                               input logic wr, input logic [2:0] prot,
                               input logic [WIDTH-1:0] wdata,
                               input logic [WIDTH-1:0] exp_data, input logic exp_err);
    bit done;
    exp_name_q.push_back(name);
    exp_data_q.push_back(exp_data);
    exp_err_q.push_back(exp_err);
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pprot   = prot;
    bus.pwdata  = wdata;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    last_waits  = 0;
    done        = 1'b0;
    while (!done) begin
      @(negedge pclk);
      if (bus.pready) begin
        done = 1'b1;
      end else begin
        last_waits++;
        if (last_waits > 50) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL %s.timeout: got no pready in %0d cycles, expected completion", name, last_waits);
          void'(exp_name_q.pop_back());
          void'(exp_data_q.pop_back());
          void'(exp_err_q.pop_back());
          done = 1'b1;
        end else begin
          @(posedge pclk); #1;
        end
      end
    end
    @(posedge pclk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic pulseReset();
    preset_n = 1'b0;
    #3;
    checkOutput("reset.pready",  {{(WIDTH-1){1'b0}}, bus.pready},  '0);
    checkOutput("reset.pslverr", {{(WIDTH-1){1'b0}}, bus.pslverr}, '0);
    checkOutput("reset.prdata",  bus.prdata, '0);
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idleCycles(1);
  endtask

  function automatic logic [WIDTH-1:0] rep32(input logic [31:0] w);
    return {(WIDTH/32){w}};
  endfunction

  function automatic logic [WIDTH-1:0] ext(input logic [31:0] w);
    return {{(WIDTH-32){1'b0}}, w};
  endfunction

  logic [WIDTH-1:0] k1, d1, v1, v2, d2;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset_n    = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pprot   = '0;
    bus.pwdata  = '0;
    @(posedge pclk); #1;
    pulseReset();

    applyStimulus("status_reset", A_STATUS, 1'b0, 3'b000, '0, '0, 1'b0);

    // Basic pad with wait states on an immediately following read
    applyStimulus("key0_wr",  A_KEY0, 1'b1, 3'b001, {16{8'hA5}}, '0, 1'b0);
    applyStimulus("ctrl_sel0", A_CTRL, 1'b1, 3'b001, ext(32'h0), '0, 1'b0);
    applyStimulus("status_valid0", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0000_0001), 1'b0);
    applyStimulus("data_wr",  A_DATA, 1'b1, 3'b000, {16{8'h0F}}, '0, 1'b0);
    applyStimulus("result_basic", A_RESULT, 1'b0, 3'b000, '0, {16{8'hAA}}, 1'b0);
    checkOutput("result_waits", ext(32'(last_waits)), ext(32'(LATENCY - 1)));
    applyStimulus("status_consumed", A_STATUS, 1'b0, 3'b000, '0, '0, 1'b0);

    // One-time use
    applyStimulus("result_again", A_RESULT, 1'b0, 3'b000, '0, '0, 1'b1);
    applyStimulus("data_no_key",  A_DATA, 1'b1, 3'b000, {16{8'h0F}}, '0, 1'b1);

    // Protection
    k1 = rep32(32'h1234_5678);
    d1 = rep32(32'hFFFF_0000);
    applyStimulus("key1_unpriv", A_KEY0 + 32'd1, 1'b1, 3'b000, k1, '0, 1'b1);
    applyStimulus("status_no_key1", A_STATUS, 1'b0, 3'b000, '0, '0, 1'b0);
    applyStimulus("key1_wr",   A_KEY0 + 32'd1, 1'b1, 3'b001, k1, '0, 1'b0);
    applyStimulus("ctrl_sel1", A_CTRL, 1'b1, 3'b001, ext(32'h1), '0, 1'b0);
    applyStimulus("data1_wr",  A_DATA, 1'b1, 3'b000, d1, '0, 1'b0);
    idleCycles(6);
    applyStimulus("status_done", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0102_0002), 1'b0);
    applyStimulus("result_nonsec", A_RESULT, 1'b0, 3'b010, '0, '0, 1'b1);
    applyStimulus("result_instr",  A_RESULT, 1'b0, 3'b100, '0, '0, 1'b1);
    applyStimulus("result_prot_ok", A_RESULT, 1'b0, 3'b000, '0, rep32(32'hEDCB_5678), 1'b0);

    // Control register errors and address map holes
    applyStimulus("ctrl_bad_sel", A_CTRL, 1'b1, 3'b001, ext(32'h4), '0, 1'b1);
    applyStimulus("ctrl_unpriv",  A_CTRL, 1'b1, 3'b000, ext(32'h1), '0, 1'b1);
    applyStimulus("ctrl_read",    A_CTRL, 1'b0, 3'b001, '0, '0, 1'b1);
    applyStimulus("status_write", A_STATUS, 1'b1, 3'b001, ext(32'hFFFF), '0, 1'b1);
    applyStimulus("key_hole",     A_KEY0 + 32'(NKEYS), 1'b1, 3'b001, k1, '0, 1'b1);
    applyStimulus("addr_04",      32'h04, 1'b0, 3'b000, '0, '0, 1'b1);
    applyStimulus("addr_hi",      32'h1000_0010, 1'b1, 3'b001, k1, '0, 1'b1);
    applyStimulus("status_after_errs", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0100_0000), 1'b0);

    // Busy behaviour, re-arm from DONE and clear-all mid-BUSY
    applyStimulus("key3_wr",   A_KEY0 + 32'd3, 1'b1, 3'b001, k1, '0, 1'b0);
    applyStimulus("ctrl_sel3", A_CTRL, 1'b1, 3'b001, ext(32'h3), '0, 1'b0);
    applyStimulus("data3_wr",  A_DATA, 1'b1, 3'b000, d1, '0, 1'b0);
    applyStimulus("data_busy", A_DATA, 1'b1, 3'b000, d1, '0, 1'b1);
    applyStimulus("status_busy", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0301_0008), 1'b0);
    applyStimulus("key3_active", A_KEY0 + 32'd3, 1'b1, 3'b001, d1, '0, 1'b1);
    applyStimulus("data_in_done", A_DATA, 1'b1, 3'b000, d1, '0, 1'b0);
    applyStimulus("clear_all", A_CTRL, 1'b1, 3'b001, ext(32'h103), '0, 1'b0);
    applyStimulus("status_cleared", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0300_0000), 1'b0);
    applyStimulus("result_cleared", A_RESULT, 1'b0, 3'b000, '0, '0, 1'b1);

    // Rewrite / lock behaviour on slot 2
    v1 = rep32(32'h1111_2222);
    v2 = rep32(32'h3333_4444);
    d2 = rep32(32'h0F0F_F0F0);
    applyStimulus("key2_first", A_KEY0 + 32'd2, 1'b1, 3'b001, v1, '0, 1'b0);
`ifdef APB_OTP_KEY_LOCK_EN
    applyStimulus("key2_second", A_KEY0 + 32'd2, 1'b1, 3'b001, v2, '0, 1'b1);
`else
    applyStimulus("key2_second", A_KEY0 + 32'd2, 1'b1, 3'b001, v2, '0, 1'b0);
`endif
    applyStimulus("ctrl_sel2", A_CTRL, 1'b1, 3'b001, ext(32'h2), '0, 1'b0);
    applyStimulus("data2_wr",  A_DATA, 1'b1, 3'b000, d2, '0, 1'b0);
    idleCycles(6);
`ifdef APB_OTP_KEY_LOCK_EN
    applyStimulus("result_key2", A_RESULT, 1'b0, 3'b000, '0, rep32(32'h1E1E_D2D2), 1'b0);
    applyStimulus("key2_after_use", A_KEY0 + 32'd2, 1'b1, 3'b001, v2, '0, 1'b1);
    applyStimulus("status_locked", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0200_0400), 1'b0);
`else
    applyStimulus("result_key2", A_RESULT, 1'b0, 3'b000, '0, rep32(32'h3C3C_B4B4), 1'b0);
    applyStimulus("key2_after_use", A_KEY0 + 32'd2, 1'b1, 3'b001, v2, '0, 1'b0);
    applyStimulus("status_rewritten", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0200_0004), 1'b0);
`endif

    pulseReset();
    applyStimulus("status_post_reset", A_STATUS, 1'b0, 3'b000, '0, '0, 1'b0);
    applyStimulus("key2_post_reset", A_KEY0 + 32'd2, 1'b1, 3'b001, v1, '0, 1'b0);
`ifdef APB_OTP_KEY_LOCK_EN
    applyStimulus("status_key2_again", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0000_0404), 1'b0);
`else
    applyStimulus("status_key2_again", A_STATUS, 1'b0, 3'b000, '0, ext(32'h0000_0004), 1'b0);
`endif

    idleCycles(3);
    checkOutput("scoreboard_drained", ext(32'(exp_data_q.size())), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/apb_otp_multikey.md
# apb_otp_multikey

Multi-slot one-time-pad engine on an APB slave port. It holds NKEYS privileged key slots and XORs a written data word with the selected key over a fixed LATENCY. The result can be read exactly once, and that read zeroizes the key that produced it. It is the next-generation OTP peripheral, sitting on the peripheral APB bus beside the security block.

## Interface
- WIDTH, 128, data/key/bus width in bits; must be ≥ 32
- NKEYS, 4, number of key slots; range 1..8
- LATENCY, 2, cycles from accepted DATA write to result ready; must be ≥ 1
- pclk  in  1  clock
- preset_n  in  1  reset, asynchronous, active-low
- paddr  in  32  word address; full 32-bit compare
- psel, penable, pwrite  in  1  APB control
- pprot  in  3  APB protection: [0] privileged, [1] non-secure, [2] instruction
- pwdata  in  WIDTH  write data
- prdata  out  WIDTH  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error

## Operation
- Address map:
  - 0x00 CTRL (W, needs pprot[0]): [2:0] key select (values ≥ NKEYS are a pslverr); [8] clear-all.
  - 0x01 DATA (W): starts an operation.
  - 0x02 RESULT (R, needs pprot[2:1]==00).
  - 0x03 STATUS (R): [7:0] valid, [15:8] locked, [16] busy, [17] done, [26:24] select.
  - 0x10+i KEY i (W, needs pprot[0]).
  - Any other address: pslverr, no effect.
- Key write: stores pwdata and sets valid[i]. Rejected with pslverr, state unchanged, if the slot is the active slot while the FSM is BUSY or DONE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE → BUSY on a DATA write when valid[sel]=1. Latches data and the active slot (sel), and loads the counter with LATENCY-1. A DATA write accepted in DONE discards the unread result without consuming the key.
  - DATA write while BUSY, or with valid[sel]=0: pslverr, ignored.
  - BUSY: counter decrements each cycle. At 0, result = data ^ key[active], then → DONE.
  - DONE → IDLE on a successful RESULT read. The result, data, key[active] and valid[active] are all zeroed on that cycle.
- RESULT read:
  - In DONE with correct pprot: returns result.
  - In IDLE: prdata 0, pslverr.
  - Wrong pprot in any state: prdata 0, pslverr, no consumption, no wait states.
  - In BUSY: wait states (see Timing).
- Clear-all: zeroes all keys, all valid bits, data and result; FSM → IDLE. Takes effect regardless of FSM state.
- Writes to read-only registers and reads of write-only registers: pslverr, prdata 0.

## Timing
- Reset values:
  - prdata 0, pready 0, pslverr 0.
  - All keys, valid, locked, data, result and sel at 0.
  - FSM in IDLE.
- Reset mid-operation aborts immediately to these values.
- prdata, pready and pslverr are combinational from the access phase (psel & penable) and current state. All three are 0 outside the access phase.
- pready is 1 in the access phase (zero wait states), except for a privileged RESULT read in BUSY. That read holds pready=0 until the FSM is in DONE, then completes in that cycle with the result.
- State updates (key store, FSM transition, consumption) occur at the pclk edge that ends the completing access phase.
- Worst-case latency: a DATA write at cycle N gives DONE at N+LATENCY. A RESULT read started at N+1 completes at N+LATENCY.

## Configuration
- APB_OTP_KEY_LOCK_EN defined:
  - A successful key write sets locked[i].
  - Any later write to a locked slot gives pslverr and is ignored.
  - locked[i] is cleared only by reset. Neither clear-all nor consumption clears it, so each slot is single-use per reset.
- Undefined: no lock bits exist, STATUS[15:8] reads 0, and slots are rewritable whenever not active.

## Test plan
- Basic pad: privileged write KEY0 = 0xA5..A5, CTRL sel=0, DATA = 0x0F..0F. Wait LATENCY cycles, then read RESULT with pprot=000 → 0xAA..AA, pslverr 0. STATUS then shows valid[0]=0.
- One-time use: repeat the RESULT read → prdata 0, pslverr 1. A DATA write with sel=0 → pslverr 1.
- Wait states: with LATENCY=4, read RESULT one cycle after the DATA write → pready low for 3 access cycles, then data delivered.
- Protection: KEY1 write with pprot=000 → pslverr, valid[1] stays 0. RESULT read with pprot=010 in DONE → pslverr, result preserved. A following pprot=000 read → correct value.
- Clear-all mid-BUSY: write CTRL[8]=1 while BUSY → STATUS = 0 (valid 0, busy 0). RESULT read → pslverr.
- Lock (macro on): write KEY2 twice → second write pslverr, first value used. After consumption, write KEY2 → pslverr; assert preset_n low → KEY2 writable again.
